priority_queue_v2: RTL and testbench
====================================

Name: priority_queue_v2

Overview:
- Parametrised next-generation priority queue for the search/scheduling datapath (frontier of best-first traversals, event ordering).
- Holds up to DEPTH {tag, data} entries and always presents the best entry at the head. Order is min-first or max-first, selected by parameter.
- Ties are stable, oldest first, tracked with an age matrix.
- Adds a ready handshake, flush, same-cycle enqueue+dequeue, overflow/underflow flags, and lowest-free-slot allocation in place of a recycled-index FIFO.

Parameters:
- DATA_WIDTH, 32, payload width.
- TAG_WIDTH, 32, priority key width (unsigned).
- DEPTH, 8, entry count, ≥2, any integer (not restricted to a power of two).
- MIN_FIRST, 1, 1 = smallest tag at head, 0 = largest tag at head.

Ports:
- clk_in  in  1  clock, rising edge.
- rst_n_in  in  1  asynchronous active-low reset.
- flush_in  in  1  synchronous clear of all entries.
- enq_in  in  1  enqueue request.
- enq_data_in  in  DATA_WIDTH  payload to enqueue.
- enq_tag_in  in  TAG_WIDTH  priority key to enqueue.
- enq_ready_out  out  1  enqueue will be accepted; equals !full_out.
- deq_in  in  1  pop the current head.
- data_out  out  DATA_WIDTH  head payload, combinational peek.
- tag_out  out  TAG_WIDTH  head key, combinational peek.
- valid_out  out  1  head is valid; equals !empty_out.
- size_out  out  $clog2(DEPTH)+1  number of stored entries.
- full_out  out  1  size_out == DEPTH.
- empty_out  out  1  size_out == 0.
- overflow_out  out  1  one-cycle registered pulse: enqueue was dropped.
- underflow_out  out  1  one-cycle registered pulse: dequeue on empty.

Behaviour:
- Reset (rst_n_in low, asynchronous assert, synchronous release handled externally):
  - All valid bits = 0; age matrix = 0; size_out = 0.
  - overflow_out = 0, underflow_out = 0.
  - Hence empty_out = 1, full_out = 0, valid_out = 0, enq_ready_out = 1.
- Storage: per slot valid bit, tag register, data register; DEPTH×DEPTH age matrix where older[i][j] = 1 means slot i was written before slot j.
- Head select (combinational):
  - Among valid slots, pick the best tag: strictly less if MIN_FIRST, else strictly greater.
  - Equal tags: the slot i with older[i][j] = 1 wins.
  - data_out and tag_out are forced to 0 when empty.
- Enqueue:
  - Accepted when enq_in && enq_ready_out.
  - Writes the lowest-index invalid slot k and sets valid[k].
  - For every currently valid j: older[j][k] ← 1, older[k][j] ← 0.
  - New entry becomes visible at the head no earlier than the next cycle. Enqueue-to-head latency is 1 cycle.
- Dequeue:
  - Accepted when deq_in && valid_out.
  - Clears valid of the head slot selected this cycle.
  - The next head is visible the following cycle.
- Simultaneous accepted enqueue and dequeue:
  - Both are performed and size_out is unchanged.
  - The popped slot is the pre-edge head; the new entry never competes for that pop.
  - Free-slot selection uses pre-edge valid bits, so the freed slot is not reused in the same cycle.
- Full:
  - enq_ready_out = 0, even when deq_in is asserted in the same cycle (no combinational ready path).
  - enq_in while full → entry dropped, overflow_out = 1 next cycle, state otherwise unchanged.
- Empty: deq_in while empty → ignored, underflow_out = 1 next cycle.
- Flush:
  - flush_in clears all valid bits and the age matrix, and sets size_out to 0.
  - Flush overrides enq_in and deq_in in the same cycle; neither is performed and no overflow/underflow is flagged.
- Size arithmetic: size_out += enq accepted − deq accepted; it never wraps.
- Reset asserted mid-operation: immediate clear of all state regardless of pending enq/deq/flush.

Test Plan:
- Reset, then enqueue tags 5, 2, 9, 2 with data 0xA, 0xB, 0xC, 0xD (MIN_FIRST = 1), then 4 dequeues → heads 2/0xB, 2/0xD, 5/0xA, 9/0xC; size 4→0; empty_out = 1 after the last pop.
- MIN_FIRST = 0 build, enqueue tags 3, 7, 7, 1 → dequeue order 7 (first inserted), 7, 3, 1.
- Fill DEPTH = 8 entries, then enq_in with deq_in in the same cycle → enqueue rejected, overflow_out pulses 1 cycle, pop performed, size_out = 7. Next cycle enq_ready_out = 1.
- Hold size 3, assert enq (tag 0) and deq in the same cycle → old head popped, size stays 3. Next cycle tag_out = 0.
- Hold size 5, assert flush_in together with enq_in → size_out = 0, valid_out = 0, overflow_out = 0. A deq_in on the next cycle → underflow_out pulses.
- Drop rst_n_in low asynchronously mid-burst, between clock edges → outputs reach reset values before the next edge. After release, enqueue tag 4 → head 4 one cycle later.

Source files
------------

// File: rtl/priority_queue_v2.sv
// rtl/priority_queue_v2.sv - stable priority queue with age-matrix tie-breaking and lowest-free-slot allocation
module priority_queue_v2 #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 32,
    parameter int DEPTH      = 8,
    parameter int MIN_FIRST  = 1,
    localparam int SIZE_W    = $clog2(DEPTH) + 1,
    localparam int IDX_W     = $clog2(DEPTH)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  flush_in,
    input  logic                  enq_in,
    input  logic [DATA_WIDTH-1:0] enq_data_in,
    input  logic [TAG_WIDTH-1:0]  enq_tag_in,
    output logic                  enq_ready_out,
    input  logic                  deq_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [TAG_WIDTH-1:0]  tag_out,
    output logic                  valid_out,
    output logic [SIZE_W-1:0]     size_out,
    output logic                  full_out,
    output logic                  empty_out,
    output logic                  overflow_out,
    output logic                  underflow_out
);

    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [TAG_WIDTH-1:0]  tag_q   [DEPTH];
    logic [TAG_WIDTH-1:0]  tag_d   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q  [DEPTH];
    logic [DATA_WIDTH-1:0] data_d  [DEPTH];
    logic [DEPTH-1:0]      older_q [DEPTH];
    logic [DEPTH-1:0]      older_d [DEPTH];
    logic [SIZE_W-1:0]     size_q, size_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic [IDX_W-1:0]      head_idx;
    logic                  head_found;
    logic [IDX_W-1:0]      free_idx;
    logic                  full, empty, enq_acc, deq_acc;

    function automatic logic better(input logic [TAG_WIDTH-1:0] a, input logic [TAG_WIDTH-1:0] b);
        return (MIN_FIRST != 0) ? (a < b) : (a > b);
    endfunction

    // Age matrix is a total order over valid slots, so a linear scan yields the stable winner.
    always_comb begin
        head_idx   = '0;
        head_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i]) begin
                if (!head_found || better(tag_q[i], tag_q[head_idx]) ||
                    (tag_q[i] == tag_q[head_idx] && older_q[i][head_idx])) begin
                    head_idx   = IDX_W'(i);
                    head_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    assign full    = (size_q == SIZE_W'(DEPTH));
    assign empty   = (size_q == '0);
    assign enq_acc = enq_in && !full && !flush_in;
    assign deq_acc = deq_in && !empty && !flush_in;

    // Free slot and age updates use pre-edge valid bits, so a slot popped this cycle is not reused.
    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        older_d     = older_q;
        size_d      = size_q;
        overflow_d  = enq_in && full && !flush_in;
        underflow_d = deq_in && empty && !flush_in;
        if (flush_in) begin
            valid_d = '0;
            size_d  = '0;
            for (int i = 0; i < DEPTH; i++) older_d[i] = '0;
        end else begin
            if (deq_acc) valid_d[head_idx] = 1'b0;
            if (enq_acc) begin
                valid_d[free_idx] = 1'b1;
                tag_d[free_idx]   = enq_tag_in;
                data_d[free_idx]  = enq_data_in;
                for (int j = 0; j < DEPTH; j++) begin
                    if (valid_q[j]) begin
                        older_d[j][free_idx] = 1'b1;
                        older_d[free_idx][j] = 1'b0;
                    end
                end
            end
            size_d = size_q + SIZE_W'(enq_acc) - SIZE_W'(deq_acc);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q     <= '0;
            size_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]   <= '0;
                data_q[i]  <= '0;
                older_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            older_q     <= older_d;
            size_q      <= size_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign enq_ready_out = !full;
    assign valid_out     = !empty;
    assign full_out      = full;
    assign empty_out     = empty;
    assign size_out      = size_q;
    assign overflow_out  = overflow_q;
    assign underflow_out = underflow_q;
    assign tag_out       = empty ? '0 : tag_q[head_idx];
    assign data_out      = empty ? '0 : data_q[head_idx];

endmodule

// File: tb/tb_priority_queue_v2.sv
// tb/tb_priority_queue_v2.sv - table-driven bench for priority_queue_v2 (min-first and max-first builds)
module tb_priority_queue_v2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    logic        enq0 = 0, deq0 = 0, enq1 = 0, deq1 = 0;
    logic [31:0] tagi0 = 0, datai0 = 0, tagi1 = 0, datai1 = 0;
    logic [31:0] tago0, datao0, tago1, datao1;
    logic [3:0]  size0, size1;
    logic        rdy0, val0, full0, emp0, ovf0, unf0;
    logic        rdy1, val1, full1, emp1, ovf1, unf1;

    priority_queue_v2 #(.DATA_WIDTH(32), .TAG_WIDTH(32), .DEPTH(8), .MIN_FIRST(1)) u_min (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .enq_in(enq0), .enq_data_in(datai0), .enq_tag_in(tagi0), .enq_ready_out(rdy0),
        .deq_in(deq0), .data_out(datao0), .tag_out(tago0), .valid_out(val0),
        .size_out(size0), .full_out(full0), .empty_out(emp0),
        .overflow_out(ovf0), .underflow_out(unf0));

    priority_queue_v2 #(.DATA_WIDTH(32), .TAG_WIDTH(32), .DEPTH(8), .MIN_FIRST(0)) u_max (
        .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush),
        .enq_in(enq1), .enq_data_in(datai1), .enq_tag_in(tagi1), .enq_ready_out(rdy1),
        .deq_in(deq1), .data_out(datao1), .tag_out(tago1), .valid_out(val1),
        .size_out(size1), .full_out(full1), .empty_out(emp1),
        .overflow_out(ovf1), .underflow_out(unf1));

    typedef struct {
        bit          sel;
        bit          enq;
        bit          deq;
        bit          flush;
        logic [31:0] tag;
        logic [31:0] data;
        int          size;
        logic [31:0] etag;
        logic [31:0] edata;
        bit          ovf;
        bit          unf;
    } vec_t;

    vec_t tv[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input bit sel, input bit enq, input bit deq, input bit fl,
                       input logic [31:0] tag, input logic [31:0] data, input int size,
                       input logic [31:0] etag, input logic [31:0] edata, input bit ovf, input bit unf);
        vec_t v;
        v.sel = sel; v.enq = enq; v.deq = deq; v.flush = fl; v.tag = tag; v.data = data;
        v.size = size; v.etag = etag; v.edata = edata; v.ovf = ovf; v.unf = unf;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // min-first ordering with a tie on tag 2
        add(0,1,0,0, 5,'hA, 1, 5,'hA, 0,0);
        add(0,1,0,0, 2,'hB, 2, 2,'hB, 0,0);
        add(0,1,0,0, 9,'hC, 3, 2,'hB, 0,0);
        add(0,1,0,0, 2,'hD, 4, 2,'hB, 0,0);
        add(0,0,1,0, 0,0,   3, 2,'hD, 0,0);
        add(0,0,1,0, 0,0,   2, 5,'hA, 0,0);
        add(0,0,1,0, 0,0,   1, 9,'hC, 0,0);
        add(0,0,1,0, 0,0,   0, 0,0,   0,0);
        add(0,0,1,0, 0,0,   0, 0,0,   0,1);
        add(0,0,0,0, 0,0,   0, 0,0,   0,0);
        // same-cycle enqueue and dequeue at size 3
        add(0,1,0,0, 6,1,   1, 6,1,   0,0);
        add(0,1,0,0, 4,2,   2, 4,2,   0,0);
        add(0,1,0,0, 8,3,   3, 4,2,   0,0);
        add(0,1,1,0, 0,4,   3, 0,4,   0,0);
        add(0,0,1,0, 0,0,   2, 6,1,   0,0);
        add(0,0,1,0, 0,0,   1, 8,3,   0,0);
        add(0,0,1,0, 0,0,   0, 0,0,   0,0);
        // flush beats enqueue, then dequeue on empty
        for (int t = 10; t < 15; t++) add(0,1,0,0, t, 'h100 + t, t - 9, 10, 'h10A, 0,0);
        add(0,1,0,1, 1,7,   0, 0,0,   0,0);
        add(0,0,1,0, 0,0,   0, 0,0,   0,1);
        add(0,0,0,0, 0,0,   0, 0,0,   0,0);
        // fill, then enqueue+dequeue while full
        for (int t = 8; t >= 1; t--) add(0,1,0,0, t, 'h20 + t, 9 - t, t, 'h20 + t, 0,0);
        add(0,1,1,0, 0,'h55, 7, 2,'h22, 1,0);
        add(0,0,0,0, 0,0,   7, 2,'h22, 0,0);
        add(0,0,0,1, 0,0,   0, 0,0,   0,0);
        add(0,0,1,1, 0,0,   0, 0,0,   0,0);
        // max-first build: tie on 7 resolves oldest first
        add(1,1,0,0, 3,1,   1, 3,1,   0,0);
        add(1,1,0,0, 7,2,   2, 7,2,   0,0);
        add(1,1,0,0, 7,3,   3, 7,2,   0,0);
        add(1,1,0,0, 1,4,   4, 7,2,   0,0);
        add(1,0,1,0, 0,0,   3, 7,3,   0,0);
        add(1,0,1,0, 0,0,   2, 3,1,   0,0);
        add(1,0,1,0, 0,0,   1, 1,4,   0,0);
        add(1,0,1,0, 0,0,   0, 0,0,   0,0);

        rst_n = 1'b0;
        #12;
        chk("reset size", 32'(size0), 0);
        chk("reset empty", 32'(emp0), 1);
        chk("reset full", 32'(full0), 0);
        chk("reset valid", 32'(val0), 0);
        chk("reset ready", 32'(rdy0), 1);
        chk("reset ovf", 32'(ovf0), 0);
        chk("reset unf", 32'(unf0), 0);
        chk("reset tag", tago0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tv[i]) begin
            logic [31:0] a_size, a_tag, a_data;
            logic        a_val, a_emp, a_full, a_rdy, a_ovf, a_unf;
            bit          e_full;
            enq0 = !tv[i].sel && tv[i].enq;  deq0 = !tv[i].sel && tv[i].deq;
            enq1 =  tv[i].sel && tv[i].enq;  deq1 =  tv[i].sel && tv[i].deq;
            tagi0 = tv[i].tag; datai0 = tv[i].data; tagi1 = tv[i].tag; datai1 = tv[i].data;
            flush = tv[i].flush;
            step();
            a_size = tv[i].sel ? 32'(size1) : 32'(size0);
            a_tag  = tv[i].sel ? tago1 : tago0;
            a_data = tv[i].sel ? datao1 : datao0;
            a_val  = tv[i].sel ? val1 : val0;
            a_emp  = tv[i].sel ? emp1 : emp0;
            a_full = tv[i].sel ? full1 : full0;
            a_rdy  = tv[i].sel ? rdy1 : rdy0;
            a_ovf  = tv[i].sel ? ovf1 : ovf0;
            a_unf  = tv[i].sel ? unf1 : unf0;
            e_full = (tv[i].size == 8);
            chk($sformatf("v%0d size", i),  a_size, 32'(tv[i].size));
            chk($sformatf("v%0d valid", i), 32'(a_val), 32'(tv[i].size != 0));
            chk($sformatf("v%0d empty", i), 32'(a_emp), 32'(tv[i].size == 0));
            chk($sformatf("v%0d full", i),  32'(a_full), 32'(e_full));
            chk($sformatf("v%0d ready", i), 32'(a_rdy), 32'(!e_full));
            chk($sformatf("v%0d tag", i),   a_tag, tv[i].etag);
            chk($sformatf("v%0d data", i),  a_data, tv[i].edata);
            chk($sformatf("v%0d ovf", i),   32'(a_ovf), 32'(tv[i].ovf));
            chk($sformatf("v%0d unf", i),   32'(a_unf), 32'(tv[i].unf));
        end
        enq0 = 0; deq0 = 0; enq1 = 0; deq1 = 0; flush = 0;

        // asynchronous reset in the middle of an enqueue burst
        enq0 = 1; tagi0 = 20; datai0 = 'h77;
        step();
        step();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async size", 32'(size0), 0);
        chk("async valid", 32'(val0), 0);
        chk("async empty", 32'(emp0), 1);
        chk("async ready", 32'(rdy0), 1);
        chk("async tag", tago0, 0);
        enq0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        enq0 = 1; tagi0 = 4; datai0 = 'h44;
        step();
        enq0 = 0;
        chk("post-reset size", 32'(size0), 1);
        chk("post-reset tag", tago0, 4);
        chk("post-reset data", datao0, 'h44);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
